// File: rtl/mini_src_pkg.sv
// Shared Mini SRC definitions: datapath widths and the memory-read FSM state type.
package mini_src_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } mem_rd_state_t;

endpackage

// File: rtl/mdr_read_ctrl_if.sv
// Memory-side read port: registered address/strobe out, ready/data back from memory.
interface mdr_read_ctrl_if #(
    parameter int DATA_W = mini_src_pkg::DATA_W,
    parameter int ADDR_W = mini_src_pkg::ADDR_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_read,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_read,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/mem_rd_timer.sv
// WAIT-phase cycle counter: restarts on request acceptance, counts while enabled,
// and flags the last permitted WAIT cycle. Saturates there, so it never wraps.
module mem_rd_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear,
    input  logic restart,
    input  logic en,
    output logic tc
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/mdr_read_ctrl.sv
// MDR read controller: accepts a word-address read request, runs the four-phase
// mem_read/mem_ready handshake with a WAIT timeout, and holds the last good word.
module mdr_read_ctrl #(
    parameter int DATA_W  = mini_src_pkg::DATA_W,
    parameter int ADDR_W  = mini_src_pkg::ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              rd_err,
    output logic [DATA_W-1:0] rd_data,
    mdr_read_ctrl_if.master   mem
);

    import mini_src_pkg::*;

    mem_rd_state_t     state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              read_q, read_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              t_restart, t_en, t_tc;

    mem_rd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .clear   (clear),
        .restart (t_restart),
        .en      (t_en),
        .tc      (t_tc)
    );

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        data_n    = data_q;
        read_n    = read_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        t_restart = 1'b0;
        t_en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    addr_n    = rd_addr;
                    read_n    = 1'b1;
                    t_restart = 1'b1;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                // A ready arriving on the last permitted cycle still counts as success.
                if (mem.mem_ready) begin
                    data_n  = mem.mem_rdata;
                    done_n  = 1'b1;
                    read_n  = 1'b0;
                    state_n = HOLD;
                end else if (t_tc) begin
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    read_n  = 1'b0;
                    state_n = HOLD;
                end else begin
                    t_en = 1'b1;
                end
            end
            HOLD: begin
                // Late ready after a timeout is absorbed here; its data is never captured.
                if (!mem.mem_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            read_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            data_q <= data_n;
            read_q <= read_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign rd_busy      = (state != IDLE);
    assign rd_done      = done_q;
    assign rd_err       = err_q;
    assign rd_data      = data_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_read = read_q;

endmodule

// File: tb/tb_mdr_read_ctrl.sv
// Bench for mdr_read_ctrl: directed vector table, hand-written corner sequences,
// then random traffic compared against a transaction-level model.
module tb_mdr_read_ctrl;

    localparam int TO = 15;

    logic        clock;
    logic        clear;
    logic        rd_req;
    logic [8:0]  rd_addr;
    logic        rd_busy;
    logic        rd_done;
    logic        rd_err;
    logic [31:0] rd_data;

    mdr_read_ctrl_if mem_bus ();

    mdr_read_ctrl #(.TIMEOUT(TO)) dut (
        .clock   (clock),
        .clear   (clear),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_busy (rd_busy),
        .rd_done (rd_done),
        .rd_err  (rd_err),
        .rd_data (rd_data),
        .mem     (mem_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        req;
        logic [8:0]  addr;
        logic        ready;
        logic [31:0] rdata;
        logic        e_busy;
        logic        e_read;
        logic [8:0]  e_addr;
        logic        e_done;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic req, input logic [8:0] addr, input logic ready,
                                input logic [31:0] rdata, input logic e_busy, input logic e_read,
                                input logic [8:0] e_addr, input logic e_done, input logic e_err,
                                input logic [31:0] e_data);
        vec_t v;
        v.req = req;       v.addr = addr;     v.ready = ready;   v.rdata = rdata;
        v.e_busy = e_busy; v.e_read = e_read; v.e_addr = e_addr;
        v.e_done = e_done; v.e_err = e_err;   v.e_data = e_data;
        return v;
    endfunction

    // Reference model: one read transaction at a time, tracked by plain flags and a wait count.
    bit          m_busy, m_strobe, m_done, m_err;
    int          m_waited;
    logic [8:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_edge();
        m_done = 0;
        m_err  = 0;
        if (!m_busy) begin
            if (rd_req) begin
                m_busy = 1; m_strobe = 1; m_addr = rd_addr; m_waited = 0;
            end
        end else if (m_strobe) begin
            if (mem_bus.mem_ready) begin
                m_data = mem_bus.mem_rdata; m_done = 1; m_strobe = 0;
            end else if (m_waited + 1 == TO) begin
                m_done = 1; m_err = 1; m_strobe = 0;
            end else begin
                m_waited++;
            end
        end else if (!mem_bus.mem_ready) begin
            m_busy = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int hi;
        int seen_done;
        int guard;

        clear = 1'b0; rd_req = 1'b0; rd_addr = '0;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;
        #12;
        check("reset busy", rd_busy, 0);
        check("reset mem_read", mem_bus.mem_read, 0);
        check("reset mem_addr", mem_bus.mem_addr, 0);
        check("reset rd_data", rd_data, 0);
        check("reset rd_done", rd_done, 0);
        check("reset rd_err", rd_err, 0);
        @(negedge clock);
        clear = 1'b1;

        // Ready held through acceptance, handshake hold with ignored requests, basic read.
        vecs.push_back(mk(1, 9'h033, 1, 32'hAAAA5555, 1, 1, 9'h033, 0, 0, 32'h0));
        vecs.push_back(mk(0, 9'h000, 1, 32'h5555AAAA, 1, 0, 9'h033, 1, 0, 32'h5555AAAA));
        vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 0, 9'h033, 0, 0, 32'h5555AAAA));
        vecs.push_back(mk(1, 9'h1C3, 0, 32'h0,        1, 1, 9'h1C3, 0, 0, 32'h5555AAAA));
        vecs.push_back(mk(0, 9'h000, 1, 32'h12345678, 1, 0, 9'h1C3, 1, 0, 32'h12345678));
        vecs.push_back(mk(1, 9'h0FF, 1, 32'h12345678, 1, 0, 9'h1C3, 0, 0, 32'h12345678));
        vecs.push_back(mk(1, 9'h0FF, 1, 32'h12345678, 1, 0, 9'h1C3, 0, 0, 32'h12345678));
        vecs.push_back(mk(1, 9'h0FF, 1, 32'h12345678, 1, 0, 9'h1C3, 0, 0, 32'h12345678));
        vecs.push_back(mk(1, 9'h0FF, 1, 32'h12345678, 1, 0, 9'h1C3, 0, 0, 32'h12345678));
        vecs.push_back(mk(1, 9'h0FF, 0, 32'h0,        0, 0, 9'h1C3, 0, 0, 32'h12345678));
        vecs.push_back(mk(1, 9'h05A, 0, 32'h0,        1, 1, 9'h05A, 0, 0, 32'h12345678));
        vecs.push_back(mk(0, 9'h000, 0, 32'h0,        1, 1, 9'h05A, 0, 0, 32'h12345678));
        vecs.push_back(mk(0, 9'h000, 1, 32'hDEADBEEF, 1, 0, 9'h05A, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 9'h000, 0, 32'h0,        0, 0, 9'h05A, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 9'h1FF, 0, 32'h0,        0, 0, 9'h05A, 0, 0, 32'hDEADBEEF));

        foreach (vecs[i]) begin
            rd_req = vecs[i].req;
            rd_addr = vecs[i].addr;
            mem_bus.mem_ready = vecs[i].ready;
            mem_bus.mem_rdata = vecs[i].rdata;
            step();
            check($sformatf("vec%0d busy", i), rd_busy, vecs[i].e_busy);
            check($sformatf("vec%0d mem_read", i), mem_bus.mem_read, vecs[i].e_read);
            check($sformatf("vec%0d mem_addr", i), mem_bus.mem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d rd_done", i), rd_done, vecs[i].e_done);
            check($sformatf("vec%0d rd_err", i), rd_err, vecs[i].e_err);
            check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].e_data);
        end

        // Timeout: mem_read high exactly TO cycles, then one done+err pulse.
        rd_req = 1'b1; rd_addr = 9'h100; mem_bus.mem_ready = 1'b0;
        step();
        rd_req = 1'b0;
        hi = 0; seen_done = 0; guard = 0;
        while (seen_done == 0 && guard < 40) begin
            if (mem_bus.mem_read) hi++;
            if (rd_done) begin
                seen_done = 1;
                check("timeout rd_err", rd_err, 1);
                check("timeout rd_data kept", rd_data, 32'hDEADBEEF);
                check("timeout mem_read low", mem_bus.mem_read, 0);
            end else begin
                step();
            end
            guard++;
        end
        check("timeout done seen", seen_done, 1);
        check("timeout mem_read cycles", hi, TO);

        // Late ready after the timeout is absorbed in HOLD.
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("late rd_done", rd_done, 0);
            check("late rd_err", rd_err, 0);
            check("late busy", rd_busy, 1);
            check("late rd_data", rd_data, 32'hDEADBEEF);
        end
        mem_bus.mem_ready = 1'b0;
        step();
        check("late idle busy", rd_busy, 0);
        check("late idle rd_data", rd_data, 32'hDEADBEEF);

        // Ready first seen on the final WAIT cycle wins over timeout.
        rd_req = 1'b1; rd_addr = 9'h0AA;
        step();
        rd_req = 1'b0;
        repeat (TO - 1) step();
        check("prio mem_read before", mem_bus.mem_read, 1);
        check("prio no early done", rd_done, 0);
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h00000001;
        step();
        check("prio rd_done", rd_done, 1);
        check("prio rd_err", rd_err, 0);
        check("prio rd_data", rd_data, 32'h00000001);
        check("prio mem_read", mem_bus.mem_read, 0);
        mem_bus.mem_ready = 1'b0;
        step();
        check("prio idle", rd_busy, 0);

        // Asynchronous clear in WAIT: immediate abort, no done pulse.
        rd_req = 1'b1; rd_addr = 9'h155;
        step();
        rd_req = 1'b0;
        step();
        check("clr pre mem_read", mem_bus.mem_read, 1);
        #2 clear = 1'b0;
        #1;
        check("clr busy", rd_busy, 0);
        check("clr mem_read", mem_bus.mem_read, 0);
        check("clr mem_addr", mem_bus.mem_addr, 0);
        check("clr rd_data", rd_data, 0);
        check("clr rd_done", rd_done, 0);
        check("clr rd_err", rd_err, 0);
        step();
        check("clr held rd_done", rd_done, 0);
        #2 clear = 1'b1;
        step();
        check("clr released busy", rd_busy, 0);
        check("clr released rd_done", rd_done, 0);

        // Random traffic against the model; DUT and model both start from reset values.
        m_busy = 0; m_strobe = 0; m_done = 0; m_err = 0; m_waited = 0;
        m_addr = '0; m_data = '0;
        for (int c = 0; c < 3000; c++) begin
            rd_req = ($urandom_range(0, 3) == 0);
            rd_addr = 9'($urandom);
            mem_bus.mem_ready = ($urandom_range(0, 7) == 0);
            mem_bus.mem_rdata = $urandom;
            @(posedge clock);
            model_edge();
            #1;
            check($sformatf("rnd%0d busy", c), rd_busy, m_busy);
            check($sformatf("rnd%0d mem_read", c), mem_bus.mem_read, m_strobe);
            check($sformatf("rnd%0d mem_addr", c), mem_bus.mem_addr, m_addr);
            check($sformatf("rnd%0d rd_done", c), rd_done, m_done);
            check($sformatf("rnd%0d rd_err", c), rd_err, m_err);
            check($sformatf("rnd%0d rd_data", c), rd_data, m_data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdr_read_ctrl.md
# mdr_read_ctrl

Memory read controller for the Mini SRC datapath. It accepts a read request carrying a word address and runs a four-phase `mem_read`/`mem_ready` handshake with the memory. It captures the returned word into a held output for loading into the MDR or driving the bus. Its dual is the register write path, which captures bus data; this block is the read side that fetches data from memory.

## Interface
Parameters:
- DATA_W, 32, data word width
- ADDR_W, 9, word address width (512-word memory)
- TIMEOUT, 15, maximum WAIT cycles without `mem_ready` before abort; legal range 1..255

Ports:
- clock  in  1  single clock; all state changes on rising edge
- clear  in  1  asynchronous, active-low reset
- rd_req  in  1  read request; sampled only in IDLE
- rd_addr  in  ADDR_W  word address; sampled with rd_req
- rd_busy  out  1  high whenever state is not IDLE
- rd_done  out  1  one-cycle pulse when a read ends (success or timeout)
- rd_err  out  1  one-cycle pulse coincident with rd_done on timeout only
- rd_data  out  DATA_W  last successfully read word; held until next successful capture
- mem_addr  out  ADDR_W  address to memory; registered; held from acceptance until next acceptance
- mem_read  out  1  read strobe to memory
- mem_ready  in  1  memory data-valid acknowledge
- mem_rdata  in  DATA_W  memory read data; valid while mem_ready=1

## Operation
- States: IDLE, WAIT, HOLD. All outputs registered.
- IDLE:
  - On rd_req=1: mem_addr<=rd_addr, mem_read<=1, count<=0, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, mem_read=1:
  - mem_ready=1: rd_data<=mem_rdata, rd_done<=1, mem_read<=0, go to HOLD.
  - mem_ready=0 and count==TIMEOUT-1: rd_done<=1, rd_err<=1, mem_read<=0, rd_data unchanged, go to HOLD.
  - Otherwise count<=count+1.
  - mem_ready has priority over timeout when both occur in the same cycle.
- HOLD, mem_read=0:
  - Wait for mem_ready=0, then go to IDLE. This completes the four-phase handshake.
  - No timeout in HOLD.
  - A late mem_ready arriving after a timeout is absorbed here; its data is discarded.
- Request handling outside IDLE: rd_req in WAIT or HOLD is ignored, not queued. rd_addr changes outside IDLE have no effect.
- Pulse width: rd_done and rd_err are high for exactly one cycle and return to 0 on the next edge.
- Counter width: clog2(TIMEOUT+1). The counter never wraps.
- Reset values: state=IDLE, mem_read=0, mem_addr=0, rd_data=0, rd_done=0, rd_err=0, rd_busy=0, count=0.
- Reset mid-operation: an asynchronous clear in WAIT or HOLD aborts immediately, drops mem_read, and produces no rd_done pulse.

## Timing
- rd_req sampled at edge k (in IDLE): from edge k, mem_read=1, mem_addr valid, and rd_busy=1.
- mem_ready sampled high at edge k+m (m>=1):
  - rd_data and rd_done=1 are valid in cycle k+m..k+m+1.
  - mem_read=0 from edge k+m.
- mem_ready sampled low at edge j in HOLD: IDLE and rd_busy=0 from edge j. Next rd_req is accepted at edge j+1 at the earliest.
- Timeout: with no mem_ready, rd_done=rd_err=1 in the cycle after edge k+TIMEOUT. mem_read is high for exactly TIMEOUT cycles.
- mem_ready held high through the acceptance edge is not sampled at that edge; sampling starts at edge k+1.

## Structure
- Shared package mini_src_pkg holds:
  - DATA_W and ADDR_W constants
  - mem_rd_state_t enum {IDLE, WAIT, HOLD}
- One sub-module, mem_rd_timer: clearable up-counter with enable and terminal-count output, parameterised by TIMEOUT.
- FSM and data capture stay in mdr_read_ctrl.

## Test plan
- Reset: clear=0 mid-WAIT with mem_read=1 -> all outputs 0 immediately, no rd_done; after release, IDLE.
- Basic read: rd_req, rd_addr=9'h05A; memory returns 32'hDEADBEEF with mem_ready 2 cycles later -> mem_addr=9'h05A, rd_data=32'hDEADBEEF, one rd_done, rd_err=0, mem_read high 2 cycles.
- Timeout: TIMEOUT=15, mem_ready never asserts -> mem_read high exactly 15 cycles; rd_done=rd_err=1 for one cycle; rd_data keeps previous value 32'hDEADBEEF.
- Same-cycle priority: mem_ready first asserts in the 15th WAIT cycle with data 32'h00000001 -> success, rd_err=0, rd_data=32'h00000001.
- Handshake hold: mem_ready stays high 4 cycles after capture -> rd_busy stays 1 until mem_ready=0; rd_req during HOLD ignored, with no second mem_read.
- Late ready after timeout: mem_ready asserts in HOLD with 32'hBAD0BAD0 -> rd_data unchanged, no extra rd_done; IDLE after mem_ready drops.
